// File: rtl/vend_pkg.sv
// Shared coin codes, controller state encoding and coin valuation for the
// newspaper vending acceptor.
package vend_pkg;

  localparam int unsigned COIN_W = 2;
  localparam int unsigned VAL_W  = 3;

  localparam logic [COIN_W-1:0] COIN_NONE    = 2'b00;
  localparam logic [COIN_W-1:0] COIN_NICKEL  = 2'b01;
  localparam logic [COIN_W-1:0] COIN_DIME    = 2'b10;
  localparam logic [COIN_W-1:0] COIN_QUARTER = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } vend_state_e;

  // Coin worth in 5-cent units.
  function automatic logic [VAL_W-1:0] coin_value(input logic [COIN_W-1:0] code);
    logic [VAL_W-1:0] val;
    val = '0;
    case (code)
      COIN_NICKEL:  val = VAL_W'(1);
      COIN_DIME:    val = VAL_W'(2);
      COIN_QUARTER: val = VAL_W'(5);
      default:      val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Loadable down-counter that returns change as one registered nickel pulse
// per unit loaded; done_c marks the cycle carrying the final pulse.
module vend_change_dispenser #(
  parameter int unsigned CW = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          pulse_o,
  output logic          done_c
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Pulse is high for every cycle the counter holds a nonzero remainder.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= (cnt_d != '0);
    end
  end

  assign pulse_o = pulse_q;
  assign done_c  = (cnt_q <= CW'(1));

endmodule

// File: rtl/vend_acceptor.sv
// Coin acceptor / dispenser controller: accumulates credit against PRICE,
// vends one paper, returns change, handles cancel, rejection and stock.
module vend_acceptor
  import vend_pkg::*;
#(
  parameter int unsigned PRICE       = 3,
  parameter int unsigned MAX_CREDIT  = 15,
  parameter int unsigned STOCK_DEPTH = 8,
  localparam int unsigned CW = $clog2(MAX_CREDIT + 1),
  localparam int unsigned SW = $clog2(STOCK_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [COIN_W-1:0] coin,
  input  logic              cancel,
  input  logic              restock,
  output logic              newspaper,
  output logic              change_nickel,
  output logic              coin_reject,
  output logic [CW-1:0]     credit,
  output logic [SW-1:0]     stock,
  output logic              sold_out,
  output logic              busy
);

  // Sum width wide enough for both the carry bit and a lone quarter.
  localparam int unsigned AW = ((CW + 1) > VAL_W) ? (CW + 1) : VAL_W;

  if (PRICE == 0 || PRICE > MAX_CREDIT) begin : g_bad_price
    $error("vend_acceptor: PRICE must lie in 1..MAX_CREDIT");
  end
  if (STOCK_DEPTH == 0) begin : g_bad_stock
    $error("vend_acceptor: STOCK_DEPTH must be at least 1");
  end

  vend_state_e   state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [SW-1:0] stock_q, stock_d;
  logic          newspaper_q, newspaper_d;
  logic          reject_q, reject_d;
  logic          sold_out_q, sold_out_d;
  logic          busy_q, busy_d;

  logic             coin_present;
  logic [VAL_W-1:0] coin_val;
  logic [AW-1:0]    sum;
  logic             over_max;
  logic             reach_price;
  logic [CW-1:0]    remainder;
  logic             disp_load;
  logic             disp_pulse;
  logic             disp_done_c;

  assign coin_present = (coin != COIN_NONE);
  assign coin_val     = coin_value(coin);
  // credit_q is zero in IDLE, so the same sum serves the first coin too.
  assign sum          = AW'(credit_q) + AW'(coin_val);
  assign over_max     = (sum > AW'(MAX_CREDIT));
  assign reach_price  = (sum >= AW'(PRICE));
  assign remainder    = credit_q - CW'(PRICE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      stock_q     <= SW'(STOCK_DEPTH);
      newspaper_q <= 1'b0;
      reject_q    <= 1'b0;
      sold_out_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      stock_q     <= stock_d;
      newspaper_q <= newspaper_d;
      reject_q    <= reject_d;
      sold_out_q  <= sold_out_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (coin_present && !sold_out_q && !over_max) begin
          state_d = reach_price ? VEND : COLLECT;
        end
      end
      COLLECT: begin
        if (cancel) begin
          state_d = CHANGE;
        end else if (coin_present && !over_max && reach_price) begin
          state_d = VEND;
        end
      end
      VEND: begin
        state_d = (remainder != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (disp_done_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates and registered-output next values.
  always_comb begin
    credit_d = credit_q;
    stock_d  = stock_q;
    reject_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (coin_present) begin
          if (sold_out_q || over_max) begin
            reject_d = 1'b1;
          end else begin
            credit_d = CW'(sum);
          end
        end
      end
      COLLECT: begin
        if (cancel) begin
          reject_d = coin_present;
        end else if (coin_present) begin
          if (over_max) begin
            reject_d = 1'b1;
          end else begin
            credit_d = CW'(sum);
          end
        end
      end
      VEND: begin
        credit_d = remainder;
        reject_d = coin_present;
        if (stock_q != '0) begin
          stock_d = stock_q - SW'(1);
        end
      end
      CHANGE: begin
        reject_d = coin_present;
        if (credit_q != '0) begin
          credit_d = credit_q - CW'(1);
        end
      end
      default: begin
        credit_d = '0;
      end
    endcase
    if (restock) begin
      stock_d = SW'(STOCK_DEPTH);
    end
    newspaper_d = (state_d == VEND);
    busy_d      = (state_d == VEND) || (state_d == CHANGE);
    sold_out_d  = (stock_d == '0);
    disp_load   = (state_d == CHANGE) && (state_q != CHANGE);
  end

  vend_change_dispenser #(
    .CW(CW)
  ) u_change (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (disp_load),
    .load_val_i (credit_d),
    .pulse_o    (disp_pulse),
    .done_c     (disp_done_c)
  );

  assign newspaper     = newspaper_q;
  assign change_nickel = disp_pulse;
  assign coin_reject   = reject_q;
  assign credit        = credit_q;
  assign stock         = stock_q;
  assign sold_out      = sold_out_q;
  assign busy          = busy_q;

endmodule

// File: doc/vend_acceptor.md
# vend_acceptor

Parametrised coin acceptor and dispenser controller for the newspaper vending machine. It accumulates credit from nickel, dime and quarter coins against a programmable price. When the price is reached it issues one vend pulse, then returns change one nickel per cycle. It also supports cancel/refund, over-credit coin rejection, and a stock counter with sold-out and restock handling. It sits between the coin mechanism front end and the dispense/change actuators.

## Interface
- PRICE, default 3: item price in 5-cent units; 1 ≤ PRICE ≤ MAX_CREDIT.
- MAX_CREDIT, default 15: maximum credit held, in 5-cent units.
- STOCK_DEPTH, default 8: number of papers after reset or restock; ≥ 1.
- Derived widths: CW = $clog2(MAX_CREDIT+1), SW = $clog2(STOCK_DEPTH+1).
- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- coin  in  2  one-cycle coin code: 00 none, 01 nickel (1 unit), 10 dime (2 units), 11 quarter (5 units).
- cancel  in  1  refund request, sampled each cycle.
- restock  in  1  reload the stock counter to STOCK_DEPTH.
- newspaper  out  1  registered one-cycle dispense pulse.
- change_nickel  out  1  registered pulse; one pulse per nickel returned.
- coin_reject  out  1  registered pulse, one cycle after a coin that was not accepted.
- credit  out  CW  current credit.
- stock  out  SW  papers remaining.
- sold_out  out  1  stock == 0.
- busy  out  1  high in VEND or CHANGE.

## Operation
- States:
  - IDLE: credit 0.
  - COLLECT: credit between 1 and PRICE-1.
  - VEND: one cycle.
  - CHANGE: returning credit.
- IDLE, on coin ≠ 00:
  - If sold_out, the coin is rejected.
  - Otherwise credit = value. Go to VEND if value ≥ PRICE, else COLLECT.
  - cancel in IDLE is ignored.
- COLLECT:
  - cancel has priority; any coin in the same cycle is rejected. Go to CHANGE.
  - Otherwise, if credit+value > MAX_CREDIT, reject the coin and hold.
  - Otherwise add the value to credit. Go to VEND if the new credit ≥ PRICE.
- VEND:
  - newspaper=1, stock−1, credit −= PRICE.
  - Next state is CHANGE if the remainder > 0, else IDLE.
- CHANGE: change_nickel=1 and credit−1 each cycle; go to IDLE after the pulse that takes credit to 0.
- Coins arriving in VEND or CHANGE are rejected; cancel is ignored there.
- restock is honoured in any state; stock = STOCK_DEPTH at the next edge. If it coincides with the VEND decrement, restock wins.
- Arithmetic is unsigned CW-bit. The sum is computed at CW+1 bits before the overflow compare, so there is no wrap.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE; credit 0; stock STOCK_DEPTH.
  - newspaper, change_nickel, coin_reject, busy all 0; sold_out 0.
- Coin reaching PRICE in cycle t: newspaper high in cycle t+1; the first change_nickel in t+2.
- Change for N units: exactly N consecutive pulses in t+2 … t+N+1; IDLE in t+N+2.
- cancel in cycle t with credit C: change pulses in t+1 … t+C.
- coin_reject is high in the cycle after the offending coin.
- credit and stock reflect the post-edge value; there is no combinational path from inputs to outputs.
- Reset mid-VEND or mid-CHANGE: all outputs drop immediately and the remaining change is forfeited.

## Structure
- Package vend_pkg:
  - coin code constants (COIN_NONE, COIN_NICKEL, COIN_DIME, COIN_QUARTER);
  - state enum (IDLE, COLLECT, VEND, CHANGE);
  - function coin_value(code) returning units.
- Sub-module vend_change_dispenser: loadable down-counter that emits change_nickel pulses and a done flag.
- Top-level vend_acceptor holds the FSM, the credit and stock registers, and the parameter assertions.

## Test plan
- Defaults; nickel×3 on consecutive cycles → newspaper pulse in the cycle after the 3rd coin; no change_nickel; stock 7; back to IDLE.
- Defaults; single quarter → newspaper at t+1; change_nickel at t+2 and t+3; credit 0; IDLE at t+4.
- Defaults; dime, then cancel two cycles later → two change_nickel pulses; no newspaper; stock stays 8. A nickel driven during CHANGE → coin_reject pulse and credit unchanged.
- PRICE=15, MAX_CREDIT=15; quarter, quarter, dime (credit 12), then quarter → coin_reject and credit stays 12. Then nickel → credit 13; dime → credit 15, newspaper; no change.
- STOCK_DEPTH=1; nickel×3 → vend; sold_out=1; next quarter → coin_reject and credit 0. restock → stock 1, sold_out 0. restock coincident with a vend → stock 1.
- Defaults; quarter, then reset_n low during the first change_nickel cycle → outputs 0 immediately. After release: credit 0, IDLE, stock at STOCK_DEPTH.
